// File: rtl/wb_slave_mem_mbx.sv
// Wishbone classic slave RAM with programmable wait states, out-of-range error response,
// and a test mailbox that compares the result word, enforces a timeout and clears its valid flag.
module wb_slave_mem_mbx #(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 1024,
    parameter int WAIT_STATES   = 0,
    parameter int MBX_VALID_ADR = 320,
    parameter int MBX_DATA_ADR  = 321,
    parameter int TIMEOUT       = 600
) (
    input  logic                  i_ck,
    input  logic                  i_rb,
    input  logic                  i_wb_we,
    input  logic [DATA_W/8-1:0]   i_wb_sel,
    input  logic [31:0]           i_wb_adr,
    input  logic [DATA_W-1:0]     i_wb_dat,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    output logic [DATA_W-1:0]     o_wb_dat,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    input  logic                  i_test_start,
    input  logic [DATA_W-1:0]     i_exp_data,
    output logic                  o_test_done,
    output logic                  o_test_pass,
    output logic                  o_test_timeout,
    output logic [DATA_W-1:0]     o_result
);

    localparam int SEL_W = DATA_W / 8;
    localparam int LSB   = $clog2(SEL_W);
    localparam int AW    = $clog2(DEPTH);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] VALID_IDX = AW'(MBX_VALID_ADR);
    localparam logic [AW-1:0] DATA_IDX  = AW'(MBX_DATA_ADR);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} bus_state_t;
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mbx_state_t;

    bus_state_t              bus_state;
    mbx_state_t              mbx_state;
    logic [3:0]              ws_cnt;
    logic [TW-1:0]           timer;

    logic [31:0]             lat_word;
    logic                    lat_we;
    logic [SEL_W-1:0]        lat_sel;
    logic [DATA_W-1:0]       lat_dat;

    logic [DATA_W-1:0]       mem_data [DEPTH];

    logic                    commit;
    logic [31:0]             c_word;
    logic                    c_we;
    logic [SEL_W-1:0]        c_sel;
    logic [DATA_W-1:0]       c_dat;
    logic                    c_in_range;
    logic [AW-1:0]           c_idx;
    logic                    flag_hit;
    logic                    done_flag;
    logic                    wr_en;

    // Byte-offset bits below the word index carry no information for this slave.
    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^(i_wb_adr & 32'((1 << LSB) - 1));

    // The access that commits on the coming edge: taken straight from the bus when there are
    // no wait states, otherwise from the request latched in IDLE.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        commit = 1'b0;
        c_word = lat_word;
        c_we   = lat_we;
        c_sel  = lat_sel;
        c_dat  = lat_dat;
        case (bus_state)
            IDLE: if (i_wb_cyc && i_wb_stb && WAIT_STATES == 0) begin
                commit = 1'b1;
                c_word = i_wb_adr >> LSB;
                c_we   = i_wb_we;
                c_sel  = i_wb_sel;
                c_dat  = i_wb_dat;
            end
            WAIT: commit = i_wb_cyc && (ws_cnt == 4'd0);
            default: commit = 1'b0;
        endcase
    end

    assign c_in_range = c_word < 32'(DEPTH);
    assign c_idx      = c_word[AW-1:0];
    assign flag_hit   = commit && c_we && c_in_range && (c_idx == VALID_IDX)
                        && c_sel[0] && c_dat[0];
    assign done_flag  = (mbx_state == M_RUN) && flag_hit && !i_test_start;
    assign wr_en      = commit && c_we && c_in_range && !done_flag;

    // NOTE: the array has no reset branch; its contents are preloaded by the bench.
    always_ff @(posedge i_ck) begin
        if (i_rb) begin
            if (wr_en) begin
                for (int k = 0; k < SEL_W; k++) begin
                    if (c_sel[k]) mem_data[c_idx][8*k +: 8] <= c_dat[8*k +: 8];
                end
            end
            // Later assignment wins: start or a consumed flag write leaves the valid word at zero.
            if (i_test_start || done_flag) mem_data[VALID_IDX] <= '0;
        end
    end

    always_ff @(posedge i_ck) begin
        if (!i_rb) begin
            // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
            bus_state <= IDLE;
            ws_cnt    <= 4'd0;
            lat_word  <= '0;
            lat_we    <= 1'b0;
            lat_sel   <= '0;
            lat_dat   <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_dat  <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= '0;
            if (commit) begin
                if (c_in_range) begin
                    o_wb_ack <= 1'b1;
                    o_wb_dat <= mem_data[c_idx];
                end else begin
                    o_wb_err <= 1'b1;
                end
            end
            case (bus_state)
                IDLE: if (i_wb_cyc && i_wb_stb) begin
                    lat_word <= i_wb_adr >> LSB;
                    lat_we   <= i_wb_we;
                    lat_sel  <= i_wb_sel;
                    lat_dat  <= i_wb_dat;
                    if (WAIT_STATES > 0) begin
                        bus_state <= WAIT;
                        ws_cnt    <= 4'(WAIT_STATES - 1);
                    end else begin
                        bus_state <= RESP;
                    end
                end
                WAIT: begin
                    if (!i_wb_cyc)            bus_state <= IDLE;
                    else if (ws_cnt == 4'd0)  bus_state <= RESP;
                    else                      ws_cnt    <= ws_cnt - 4'd1;
                end
                RESP:    bus_state <= IDLE;
                default: bus_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_ck) begin
        if (!i_rb) begin
            mbx_state      <= M_IDLE;
            timer          <= '0;
            o_test_done    <= 1'b0;
            o_test_pass    <= 1'b0;
            o_test_timeout <= 1'b0;
            o_result       <= '0;
        end else begin
            o_test_done <= 1'b0;
            if (i_test_start) begin
                o_test_pass    <= 1'b0;
                o_test_timeout <= 1'b0;
                timer          <= TW'(TIMEOUT);
                mbx_state      <= M_RUN;
            end else if (mbx_state == M_RUN) begin
                // A flag write on the final budget cycle still counts as completion.
                if (flag_hit) begin
                    o_result    <= mem_data[DATA_IDX];
                    o_test_pass <= (mem_data[DATA_IDX] == i_exp_data);
                    o_test_done <= 1'b1;
                    mbx_state   <= M_DONE;
                end else if (timer < TW'(2)) begin
                    timer          <= '0;
                    o_test_timeout <= 1'b1;
                    o_test_pass    <= 1'b0;
                    o_test_done    <= 1'b1;
                    mbx_state      <= M_DONE;
                end else begin
                    timer <= timer - TW'(1);
                end
            end
        end
    end

endmodule
